// File: rtl/ram_streamer_pkg.sv
// rtl/ram_streamer_pkg.sv - shared state encodings and constants for the RAM streamer
//
// Purpose : state encoding, command encoding and default RAM address width.
// Ports   : none (package). RAM_ADDR_BITS may be predefined to change the default depth.
`ifndef RAM_ADDR_BITS
`define RAM_ADDR_BITS 8
`endif

package ram_streamer_pkg;

    localparam int DEFAULT_ADDR_BITS = `RAM_ADDR_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DUMP = 2'd2
    } state_e;

    localparam logic CMD_FILL = 1'b1;
    localparam logic CMD_DUMP = 1'b0;

endpackage

// File: rtl/ram_streamer_if.sv
// rtl/ram_streamer_if.sv - command, byte-stream, status and RAM-port bundle of the streamer
//
// Purpose : groups every non-clock/reset signal of ram_streamer.
// Ports   : slave modport = streamer view, master modport = host/RAM-model view.
//           cmd_*  command handshake, in_*  FILL stream, out_*  DUMP stream,
//           busy/done status, ram_* single-port RAM, cksum (RAM_STREAMER_CKSUM_EN only).
interface ram_streamer_if
    import ram_streamer_pkg::*;
#(
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int WIDTH     = 8
);

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [ADDR_BITS-1:0] cmd_base;
    logic [ADDR_BITS-1:0] cmd_len;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 busy;
    logic                 done;
    logic                 ram_we;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [WIDTH-1:0]     ram_di;
    logic [WIDTH-1:0]     ram_do;
`ifdef RAM_STREAMER_CKSUM_EN
    logic [7:0]           cksum;

    modport slave (
        input  cmd_valid, cmd_write, cmd_base, cmd_len, in_valid, in_data, out_ready, ram_do,
        output cmd_ready, in_ready, out_valid, out_data, busy, done, ram_we, ram_addr, ram_di,
               cksum
    );

    modport master (
        output cmd_valid, cmd_write, cmd_base, cmd_len, in_valid, in_data, out_ready, ram_do,
        input  cmd_ready, in_ready, out_valid, out_data, busy, done, ram_we, ram_addr, ram_di,
               cksum
    );
`else
    modport slave (
        input  cmd_valid, cmd_write, cmd_base, cmd_len, in_valid, in_data, out_ready, ram_do,
        output cmd_ready, in_ready, out_valid, out_data, busy, done, ram_we, ram_addr, ram_di
    );

    modport master (
        output cmd_valid, cmd_write, cmd_base, cmd_len, in_valid, in_data, out_ready, ram_do,
        input  cmd_ready, in_ready, out_valid, out_data, busy, done, ram_we, ram_addr, ram_di
    );
`endif

endinterface

// File: rtl/ram_streamer_fifo2.sv
// rtl/ram_streamer_fifo2.sv - two-entry byte FIFO buffering DUMP read data
//
// Purpose : holds RAM read data until the DUMP sink takes it.
// Ports   : clk, rst_n (sync active-low), flush (drop contents), push/push_data,
//           pop, count (0..2), head (oldest entry, meaningful when count != 0).
module ram_streamer_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [2];
    logic             rd_q;
    logic             wr_q;
    logic [1:0]       cnt_q;

    // Callers never push when full without a same-cycle pop, nor pop when empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (flush) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= push_data;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign count = cnt_q;
    assign head  = mem_q[rd_q];

endmodule

// File: rtl/ram_streamer.sv
// rtl/ram_streamer.sv - FILL/DUMP command engine owning the single-port byte RAM
//
// Purpose : FILL writes an input byte stream to consecutive addresses; DUMP streams
//           consecutive addresses out. One command at a time, addresses wrap.
// Ports   : clk, rst_n (sync active-low), bus (ram_streamer_if.slave: cmd_*, in_*,
//           out_*, busy, done, ram_*).
// Option  : RAM_STREAMER_CKSUM_EN adds bus.cksum, mod-256 sum of bytes moved by the
//           current command.
module ram_streamer
    import ram_streamer_pkg::*;
#(
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int WIDTH     = 8
) (
    input logic           clk,
    input logic           rst_n,
    ram_streamer_if.slave bus
);

    localparam logic [ADDR_BITS-1:0] A_ONE = ADDR_BITS'(1);

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] ptr_q, ptr_d;
    logic [ADDR_BITS-1:0] rem_q, rem_d;
    logic                 inflight_q, inflight_d;
    logic                 last_q, last_d;
    logic                 done_q, done_d;

    logic [1:0]           fifo_count;
    logic [WIDTH-1:0]     fifo_head;
    logic                 accept;
    logic                 issue_first;
    logic                 fill_beat;
    logic                 pop;
    logic                 room;
    logic                 issue;
    logic                 final_pop;

    assign accept      = (state_q == ST_IDLE) && bus.cmd_valid;
    // The first DUMP read is issued in the accept cycle so data appears two cycles later.
    assign issue_first = accept && (bus.cmd_write == CMD_DUMP);
    assign fill_beat   = (state_q == ST_FILL) && bus.in_valid;
    assign pop         = (state_q == ST_DUMP) && (fifo_count != 2'd0) && bus.out_ready;
    // FIFO occupancy plus the outstanding read must stay within the two FIFO slots.
    assign room        = (fifo_count == 2'd0) || ((fifo_count == 2'd1) && !inflight_q);
    assign issue       = (state_q == ST_DUMP) && !last_q && (room || pop);
    assign final_pop   = pop && last_q && !inflight_q && (fifo_count == 2'd1);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        inflight_d = 1'b0;
        last_d     = last_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rem_d = bus.cmd_len;
                    if (bus.cmd_write == CMD_FILL) begin
                        ptr_d   = bus.cmd_base;
                        state_d = ST_FILL;
                    end else begin
                        ptr_d      = bus.cmd_base + A_ONE;
                        inflight_d = 1'b1;
                        last_d     = (bus.cmd_len == '0);
                        state_d    = ST_DUMP;
                    end
                end
            end
            ST_FILL: begin
                if (bus.in_valid) begin
                    ptr_d = ptr_q + A_ONE;
                    if (rem_q == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rem_d = rem_q - A_ONE;
                    end
                end
            end
            ST_DUMP: begin
                // In DUMP, rem_q counts reads still to issue after the accept-cycle read.
                if (issue) begin
                    ptr_d      = ptr_q + A_ONE;
                    inflight_d = 1'b1;
                    rem_d      = rem_q - A_ONE;
                    last_d     = (rem_q == A_ONE);
                end
                if (final_pop) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            inflight_q <= inflight_d;
            last_q     <= last_d;
            done_q     <= done_d;
        end
    end

    // A read issued last cycle has its data on ram_do now.
    ram_streamer_fifo2 #(.WIDTH(WIDTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (accept),
        .push      (inflight_q),
        .push_data (bus.ram_do),
        .pop       (pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
    // Gated by rst_n so a FILL interrupted by reset cannot write in the reset cycle.
    assign bus.in_ready  = rst_n && (state_q == ST_FILL);
    assign bus.ram_we    = rst_n && fill_beat;
    assign bus.ram_addr  = issue_first ? bus.cmd_base : ptr_q;
    assign bus.ram_di    = (state_q == ST_FILL) ? bus.in_data : '0;
    assign bus.out_valid = (fifo_count != 2'd0);
    assign bus.out_data  = fifo_head;

`ifdef RAM_STREAMER_CKSUM_EN
    logic [7:0] cksum_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cksum_q <= 8'h00;
        end else if (accept) begin
            cksum_q <= 8'h00;
        end else if (fill_beat) begin
            cksum_q <= cksum_q + bus.in_data;
        end else if (pop) begin
            cksum_q <= cksum_q + fifo_head;
        end
    end

    assign bus.cksum = cksum_q;
`endif

endmodule

// File: tb/tb_ram_streamer.sv
// tb/tb_ram_streamer.sv - self-checking bench for ram_streamer
module tb_ram_streamer;

    localparam int AB = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_streamer_if #(.ADDR_BITS(AB), .WIDTH(8)) bus ();

    ram_streamer #(.ADDR_BITS(AB), .WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem    [256];
    logic [7:0]  shadow [256];
    logic [7:0]  exp_q  [$];
    logic [15:0] exp_wq [$];

    typedef struct {
        bit wr;
        int base;
        int len;
        int gap;
        int rdy;
        int d0;
        int step;
        int lat;
    } cmd_t;

    // Single-port RAM model: registered read, write-first on the same address.
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_di;
        bus.ram_do <= bus.ram_we ? bus.ram_di : mem[bus.ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_cmd(input cmd_t c);
        int t = 0;
        int i = 0;
        int n_io = 0;
        int first_v = -1;
        int first_io = -1;
        int last_io = -1;
        bit got_done = 1'b0;
        bit stall = 1'b0;
        logic [7:0]  prev = 8'h00;
        logic [7:0]  es = 8'h00;
        logic [7:0]  b;
        logic [7:0]  addr;
        logic [7:0]  ed;
        logic [15:0] ew;
        logic [7:0]  sp [3] = '{8'hFF, 8'h02, 8'h10};
        bus.cmd_valid = 1'b1;
        bus.cmd_write = c.wr;
        bus.cmd_base  = 8'(c.base);
        bus.cmd_len   = 8'(c.len);
        #1;
        chk("cmd_ready_at_accept", 32'(bus.cmd_ready), 1);
        if (!c.wr) begin
            chk("dump_first_addr", 32'(bus.ram_addr), c.base);
            for (int k = 0; k <= c.len; k++) exp_q.push_back(shadow[8'(c.base + k)]);
        end
        while (!got_done && t < 1000) begin
            @(negedge clk);
            t++;
            bus.cmd_valid = 1'b0;
            if (c.wr) begin
                if (i <= c.len && ((t - 1) % c.gap) == 0) begin
                    b    = (c.step == 0) ? sp[i] : 8'(c.d0 + i * c.step);
                    addr = 8'(c.base + i);
                    bus.in_valid = 1'b1;
                    bus.in_data  = b;
                    exp_wq.push_back({addr, b});
                    shadow[addr] = b;
                    es += b;
                    i++;
                end else begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = 8'h00;
                end
            end else begin
                bus.out_ready = (c.rdy == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            #1;
`ifdef RAM_STREAMER_CKSUM_EN
            if (t == 1) chk("cksum_cleared", 32'(bus.cksum), 0);
`endif
            if (c.wr) begin
                if (bus.ram_we) begin
                    n_io++;
                    last_io = t;
                    if (exp_wq.size() > 0) begin
                        ew = exp_wq.pop_front();
                        chk("fill_addr", 32'(bus.ram_addr), 32'(ew[15:8]));
                        chk("fill_data", 32'(bus.ram_di), 32'(ew[7:0]));
                    end
                end
            end else begin
                chk("dump_no_we", 32'(bus.ram_we), 0);
                if (stall) begin
                    chk("stall_valid", 32'(bus.out_valid), 1);
                    chk("stall_data", 32'(bus.out_data), 32'(prev));
                end
                if (bus.out_valid && first_v < 0) first_v = t;
                if (bus.out_valid && bus.out_ready) begin
                    n_io++;
                    if (first_io < 0) first_io = t;
                    last_io = t;
                    if (exp_q.size() > 0) begin
                        ed = exp_q.pop_front();
                        chk("dump_data", 32'(bus.out_data), 32'(ed));
                        es += ed;
                    end
                end
                stall = bus.out_valid && !bus.out_ready;
                prev  = bus.out_data;
            end
            if (bus.done) got_done = 1'b1;
        end
        chk("done_seen", 32'(got_done), 1);
        chk("byte_count", n_io, c.len + 1);
        chk("done_latency", t - last_io, 1);
        chk("idle_at_done", 32'({bus.busy, bus.cmd_ready}), 1);
        if (c.wr) begin
            chk("fill_all_written", exp_wq.size(), 0);
        end else begin
            chk("dump_all_read", exp_q.size(), 0);
            chk("first_valid_latency", first_v, c.lat);
            if (c.rdy == 0) chk("dump_throughput", last_io - first_io, c.len);
        end
`ifdef RAM_STREAMER_CKSUM_EN
        chk("cksum_final", 32'(bus.cksum), 32'(es));
`endif
        bus.in_valid = 1'b0;
        exp_q.delete();
        exp_wq.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        cmd_t vec [10];
        cmd_t c;
        int   n;
        int   dn;

        vec[0] = '{1'b1, 'h00, 255, 1, 0, 'h3C, 1,    2};
        vec[1] = '{1'b0, 'h00, 255, 1, 0, 0,    0,    2};
        vec[2] = '{1'b1, 'h10, 3,   1, 0, 'hA1, 'h11, 2};
        vec[3] = '{1'b0, 'h10, 3,   1, 0, 0,    0,    2};
        vec[4] = '{1'b1, 'hFE, 3,   1, 0, 'h11, 'h11, 2};
        vec[5] = '{1'b0, 'hFE, 3,   1, 0, 0,    0,    2};
        vec[6] = '{1'b0, 'h20, 7,   1, 1, 0,    0,    2};
        vec[7] = '{1'b1, 'h40, 0,   3, 0, 'h77, 1,    2};
        vec[8] = '{1'b0, 'h40, 0,   1, 0, 0,    0,    2};
        vec[9] = '{1'b0, 'h30, 5,   1, 0, 0,    0,    2};

        for (int k = 0; k < 256; k++) begin
            mem[k]    = 8'h00;
            shadow[k] = 8'h00;
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_base  = 8'h00;
        bus.cmd_len   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("rst_busy",      32'(bus.busy), 0);
        chk("rst_done",      32'(bus.done), 0);
        chk("rst_in_ready",  32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data",  32'(bus.out_data), 0);
        chk("rst_ram_we",    32'(bus.ram_we), 0);
        chk("rst_ram_addr",  32'(bus.ram_addr), 0);
        chk("rst_ram_di",    32'(bus.ram_di), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        for (int v = 0; v < 9; v++) run_cmd(vec[v]);

        // Reset during FILL: the byte presented in the reset cycle must not be written.
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_base  = 8'h60;
        bus.cmd_len   = 8'd5;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h91;
        shadow[8'h60] = 8'h91;
        #1;
        chk("fill_rst_first_addr", 32'(bus.ram_addr), 'h60);
        @(negedge clk);
        bus.in_data   = 8'h92;
        shadow[8'h61] = 8'h92;
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_data = 8'h93;
        #1;
        chk("reset_no_write", 32'(bus.ram_we), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("fill_abort_busy", 32'(bus.busy), 0);

        // Reset during DUMP after two bytes popped.
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_base  = 8'h30;
        bus.cmd_len   = 8'd5;
        bus.out_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 10 && n < 2; k++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                chk("abort_dump_data", 32'(bus.out_data), 32'(shadow[8'(8'h30 + n)]));
                n++;
            end
        end
        chk("pops_before_reset", n, 2);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_out_valid", 32'(bus.out_valid), 0);
        chk("abort_busy",      32'(bus.busy), 0);
        chk("abort_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("abort_out_data",  32'(bus.out_data), 0);
        dn = bus.done ? 1 : 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (bus.done) dn++;
        end
        chk("abort_no_done", dn, 0);

        run_cmd(vec[9]);
        c = '{1'b0, 'h60, 2, 1, 0, 0, 0, 2};
        run_cmd(c);

        c = '{1'b1, 'h70, 2, 1, 0, 0, 0, 2};
        run_cmd(c);
`ifdef RAM_STREAMER_CKSUM_EN
        chk("cksum_ff_02_10", 32'(bus.cksum), 'h11);
`endif
        c = '{1'b0, 'h70, 2, 1, 1, 0, 0, 2};
        run_cmd(c);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
